// File: rtl/tv80_pkg.sv
// rtl/tv80_pkg.sv - shared constants and helpers for the TV80 bus controller
package tv80_pkg;

    // Bit positions inside the one-hot ts/mc vectors from the core
    localparam int MC_M1 = 0;
    localparam int TS_T1 = 1;
    localparam int TS_T2 = 2;
    localparam int TS_T3 = 3;

    // Wait-state counter width (wait parameters range 0..7)
    localparam int CNT_W = 3;

    // External-wait timeout
    localparam int         TOUT_W     = 8;
    localparam logic [7:0] TOUT_LIMIT = 8'd255;

    // Which wait parameter seeds the counter for the current machine cycle
    typedef enum logic [1:0] {
        WSRC_M1  = 2'd0,
        WSRC_IO  = 2'd1,
        WSRC_MEM = 2'd2
    } wait_src_e;

    // Interrupt acknowledge is an M1 cycle but is timed like I/O
    function automatic wait_src_e wait_src(input logic m1,
                                           input logic intcycle_n,
                                           input logic iorq);
        if (m1)
            return intcycle_n ? WSRC_M1 : WSRC_IO;
        else if (iorq)
            return WSRC_IO;
        else
            return WSRC_MEM;
    endfunction

endpackage

// File: rtl/tv80_wait_gen.sv
// rtl/tv80_wait_gen.sv - wait-state counter and optional external-wait timeout
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   i_m1              current machine cycle is M1
//   i_intcycle_n      low during interrupt-acknowledge M1
//   i_iorq            current cycle is I/O
//   i_ts1, i_ts2      T1 / T2 state flags
//   i_wait_n          external wait request, active low
//   o_core_wait_n     merged wait to the core
//   o_bus_err         one-cycle pulse on wait timeout
//
// Build option: TV80_WAIT_TIMEOUT_EN enables the timeout counter; without it
// o_bus_err is tied low and the external wait is passed straight through.
module tv80_wait_gen
    import tv80_pkg::*;
#(
    parameter int MEM_WAIT = 0,
    parameter int IO_WAIT  = 1,
    parameter int M1_WAIT  = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_m1,
    input  logic i_intcycle_n,
    input  logic i_iorq,
    input  logic i_ts1,
    input  logic i_ts2,
    input  logic i_wait_n,
    output logic o_core_wait_n,
    output logic o_bus_err
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_load;
    logic             w_cnt_zero;

    always_comb begin
        w_load = CNT_W'(MEM_WAIT);
        case (wait_src(i_m1, i_intcycle_n, i_iorq))
            WSRC_M1:  w_load = CNT_W'(M1_WAIT);
            WSRC_IO:  w_load = CNT_W'(IO_WAIT);
            default:  w_load = CNT_W'(MEM_WAIT);
        endcase
    end

    // T1 always reloads, even over a countdown still in progress
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_cnt <= '0;
        else if (i_ts1)
            r_cnt <= w_load;
        else if (r_cnt != '0)
            r_cnt <= r_cnt - CNT_W'(1);
    end

    assign w_cnt_zero = (r_cnt == '0);

`ifdef TV80_WAIT_TIMEOUT_EN
    logic [TOUT_W-1:0] r_tcnt;
    logic              r_tout;
    logic              r_bus_err;
    logic              w_count_en;
    logic              w_hit;

    assign w_count_en = i_ts2 & w_cnt_zero & ~i_wait_n;
    assign w_hit      = w_count_en && (r_tcnt == TOUT_LIMIT - 8'd1);

    // tcnt saturates at the limit so the error fires only once per stall;
    // edges where internal wait states are still running neither count nor clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tcnt    <= '0;
            r_tout    <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            if (!i_ts2 || i_wait_n)
                r_tcnt <= '0;
            else if (w_count_en && r_tcnt != TOUT_LIMIT)
                r_tcnt <= r_tcnt + 8'd1;

            if (!i_ts2)
                r_tout <= 1'b0;
            else if (w_hit)
                r_tout <= 1'b1;

            r_bus_err <= w_hit;
        end
    end

    // Once timed out, release the core until it leaves T2
    assign o_core_wait_n = r_tout | (i_wait_n & w_cnt_zero);
    assign o_bus_err     = r_bus_err;
`else
    assign o_core_wait_n = i_wait_n & w_cnt_zero;
    assign o_bus_err     = 1'b0;
`endif

endmodule

// File: rtl/tv80_bus_ctl.sv
// rtl/tv80_bus_ctl.sv - TV80 bus strobe generator, wait merging and read-data latch
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   mc[6:0]               one-hot machine cycle (bit0 = M1)
//   ts[6:0]               one-hot T-state (bit1 = T1, bit2 = T2, bit3 = T3)
//   intcycle_n            low during interrupt-acknowledge M1
//   no_read, write, iorq  cycle qualifiers from the core
//   wait_n                external wait request, active low
//   di[7:0]               external data bus
//   core_wait_n           merged wait to the core
//   rd_n, wr_n, mreq_n, iorq_n   registered bus strobes, active low
//   di_reg[7:0]           latched read data
//   bus_err               one-cycle pulse on wait timeout
//
// Build option: TV80_WAIT_TIMEOUT_EN enables the external-wait timeout.
module tv80_bus_ctl
    import tv80_pkg::*;
#(
    parameter int T2WRITE  = 0,
    parameter int MEM_WAIT = 0,
    parameter int IO_WAIT  = 1,
    parameter int M1_WAIT  = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] mc,
    input  logic [6:0] ts,
    input  logic       intcycle_n,
    input  logic       no_read,
    input  logic       write,
    input  logic       iorq,
    input  logic       wait_n,
    input  logic [7:0] di,
    output logic       core_wait_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       mreq_n,
    output logic       iorq_n,
    output logic [7:0] di_reg,
    output logic       bus_err
);

    localparam bit EARLY_WR = (T2WRITE != 0);

    logic w_m1, w_t1, w_t2, w_t3;
    logic w_core_wait_n;
    logic w_addr_ph;
    logic w_wr_ph;
    logic w_rd_n, w_wr_n, w_mreq_n, w_iorq_n;
    logic r_rd_n, r_wr_n, r_mreq_n, r_iorq_n;
    logic [7:0] r_di;
    logic w_unused;

    assign w_m1 = mc[MC_M1];
    assign w_t1 = ts[TS_T1];
    assign w_t2 = ts[TS_T2];
    assign w_t3 = ts[TS_T3];

    assign w_unused = ^{mc[6:1], ts[6:4], ts[0]};

    tv80_wait_gen #(
        .MEM_WAIT (MEM_WAIT),
        .IO_WAIT  (IO_WAIT),
        .M1_WAIT  (M1_WAIT)
    ) u_wait_gen (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_m1          (w_m1),
        .i_intcycle_n  (intcycle_n),
        .i_iorq        (iorq),
        .i_ts1         (w_t1),
        .i_ts2         (w_t2),
        .i_wait_n      (wait_n),
        .o_core_wait_n (w_core_wait_n),
        .o_bus_err     (bus_err)
    );

    // Strobes are asserted from the T1 edge and held across wait-stretched T2s;
    // the final T2 edge (wait released) lets them return high
    assign w_addr_ph = w_t1 | (w_t2 & ~w_core_wait_n);

    // Write address strobes follow wr_n so a late (T2) write keeps
    // iorq_n/mreq_n aligned with the write pulse
    assign w_wr_ph = EARLY_WR ? w_addr_ph : w_t2;

    always_comb begin
        w_rd_n   = 1'b1;
        w_wr_n   = 1'b1;
        w_mreq_n = 1'b1;
        w_iorq_n = 1'b1;
        if (w_m1) begin
            if (w_addr_ph) begin
                w_rd_n   = ~intcycle_n;
                w_mreq_n = ~intcycle_n;
                w_iorq_n = intcycle_n;
            end
            // Refresh strobe during T3 of every M1
            if (w_t3)
                w_mreq_n = 1'b0;
        end else if (write) begin
            if (w_wr_ph) begin
                w_wr_n   = 1'b0;
                w_iorq_n = ~iorq;
                w_mreq_n = iorq;
            end
        end else if (!no_read) begin
            if (w_addr_ph) begin
                w_rd_n   = 1'b0;
                w_iorq_n = ~iorq;
                w_mreq_n = iorq;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_n   <= 1'b1;
            r_wr_n   <= 1'b1;
            r_mreq_n <= 1'b1;
            r_iorq_n <= 1'b1;
            r_di     <= 8'h00;
        end else begin
            r_rd_n   <= w_rd_n;
            r_wr_n   <= w_wr_n;
            r_mreq_n <= w_mreq_n;
            r_iorq_n <= w_iorq_n;
            if (w_t2 && w_core_wait_n)
                r_di <= di;
        end
    end

    assign core_wait_n = w_core_wait_n;
    assign rd_n        = r_rd_n;
    assign wr_n        = r_wr_n;
    assign mreq_n      = r_mreq_n;
    assign iorq_n      = r_iorq_n;
    assign di_reg      = r_di;

endmodule

// File: tb/tb_tv80_bus_ctl.sv
// tb/tb_tv80_bus_ctl.sv - self-checking bench for tv80_bus_ctl
module tb_tv80_bus_ctl;

    localparam logic [6:0] M1 = 7'b0000001;
    localparam logic [6:0] M2 = 7'b0000010;
    localparam logic [6:0] M3 = 7'b0000100;
    localparam logic [6:0] TN = 7'b0000000;
    localparam logic [6:0] T1 = 7'b0000010;
    localparam logic [6:0] T2 = 7'b0000100;
    localparam logic [6:0] T3 = 7'b0001000;
    localparam logic [6:0] T4 = 7'b0010000;

    logic       clk;
    logic       reset_n;
    logic [6:0] mc, ts;
    logic       intcycle_n, no_read, write, iorq, wait_n;
    logic [7:0] di;

    logic       cwn_d, rd_d, wr_d, mreq_d, iorq_d, err_d;
    logic [7:0] dreg_d;
    logic       cwn_w, rd_w, wr_w, mreq_w, iorq_w, err_w;
    logic [7:0] dreg_w;

    int n_chk;
    int n_err;

    tv80_bus_ctl #(.T2WRITE(0), .MEM_WAIT(2), .IO_WAIT(1), .M1_WAIT(0)) dut (
        .clk(clk), .reset_n(reset_n), .mc(mc), .ts(ts), .intcycle_n(intcycle_n),
        .no_read(no_read), .write(write), .iorq(iorq), .wait_n(wait_n), .di(di),
        .core_wait_n(cwn_d), .rd_n(rd_d), .wr_n(wr_d), .mreq_n(mreq_d),
        .iorq_n(iorq_d), .di_reg(dreg_d), .bus_err(err_d)
    );

    tv80_bus_ctl #(.T2WRITE(1), .MEM_WAIT(3), .IO_WAIT(1), .M1_WAIT(0)) dut_w (
        .clk(clk), .reset_n(reset_n), .mc(mc), .ts(ts), .intcycle_n(intcycle_n),
        .no_read(no_read), .write(write), .iorq(iorq), .wait_n(wait_n), .di(di),
        .core_wait_n(cwn_w), .rd_n(rd_w), .wr_n(wr_w), .mreq_n(mreq_w),
        .iorq_n(iorq_w), .di_reg(dreg_w), .bus_err(err_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] mc;
        logic [6:0] ts;
        logic       intc_n, no_rd, wr, io, wait_n;
        logic [7:0] di;
        logic       cwn;
        logic       rd_n, wr_n, mreq_n, iorq_n;
        logic [7:0] di_reg;
        logic       wr_n_w;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic [6:0] m, logic [6:0] t, logic ic, logic nr,
                               logic w, logic io, logic wn, logic [7:0] d, logic c,
                               logic r, logic wrn, logic mq, logic iq,
                               logic [7:0] dr, logic ww);
        vec_t x;
        x.mc = m; x.ts = t; x.intc_n = ic; x.no_rd = nr; x.wr = w; x.io = io;
        x.wait_n = wn; x.di = d; x.cwn = c; x.rd_n = r; x.wr_n = wrn;
        x.mreq_n = mq; x.iorq_n = iq; x.di_reg = dr; x.wr_n_w = ww;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] m, input logic [6:0] t, input logic ic,
                         input logic nr, input logic w, input logic io,
                         input logic wn, input logic [7:0] d);
        mc = m; ts = t; intcycle_n = ic; no_read = nr; write = w; iorq = io;
        wait_n = wn; di = d;
    endtask

    int first_d, first_w, pulses_d, pulses_w, hi_d;

    initial begin
        n_chk = 0;
        n_err = 0;
        reset_n = 1'b0;
        drive(TN, TN, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);

        // A: memory read, MEM_WAIT=2
        tbl.push_back(v(M2,T1,1,0,0,0,1,8'h00, 1, 0,1,0,1, 8'h00, 1));
        tbl.push_back(v(M2,T2,1,0,0,0,1,8'hA5, 0, 0,1,0,1, 8'h00, 1));
        tbl.push_back(v(M2,T2,1,0,0,0,1,8'hA5, 0, 0,1,0,1, 8'h00, 1));
        tbl.push_back(v(M2,T2,1,0,0,0,1,8'hA5, 1, 1,1,1,1, 8'hA5, 1));
        tbl.push_back(v(M2,T3,1,0,0,0,1,8'h3C, 1, 1,1,1,1, 8'hA5, 1));
        // B: I/O write, IO_WAIT=1
        tbl.push_back(v(M3,T1,1,0,1,1,1,8'h3C, 1, 1,1,1,1, 8'hA5, 0));
        tbl.push_back(v(M3,T2,1,0,1,1,1,8'h3C, 0, 1,0,1,0, 8'hA5, 0));
        tbl.push_back(v(M3,T2,1,0,1,1,1,8'h3C, 1, 1,0,1,0, 8'h3C, 1));
        tbl.push_back(v(M3,T3,1,0,1,1,1,8'h3C, 1, 1,1,1,1, 8'h3C, 1));
        // C: M1 fetch with three external wait cycles, refresh in T3
        tbl.push_back(v(M1,T1,1,0,0,0,1,8'h77, 1, 0,1,0,1, 8'h3C, 1));
        tbl.push_back(v(M1,T2,1,0,0,0,0,8'h77, 0, 0,1,0,1, 8'h3C, 1));
        tbl.push_back(v(M1,T2,1,0,0,0,0,8'h77, 0, 0,1,0,1, 8'h3C, 1));
        tbl.push_back(v(M1,T2,1,0,0,0,0,8'h77, 0, 0,1,0,1, 8'h3C, 1));
        tbl.push_back(v(M1,T2,1,0,0,0,1,8'h77, 1, 1,1,1,1, 8'h77, 1));
        tbl.push_back(v(M1,T3,1,0,0,0,1,8'h77, 1, 1,1,0,1, 8'h77, 1));
        tbl.push_back(v(M1,T4,1,0,0,0,1,8'h77, 1, 1,1,1,1, 8'h77, 1));
        // D: interrupt acknowledge, IO_WAIT waits
        tbl.push_back(v(M1,T1,0,0,0,0,1,8'hFF, 1, 1,1,1,0, 8'h77, 1));
        tbl.push_back(v(M1,T2,0,0,0,0,1,8'hFF, 0, 1,1,1,0, 8'h77, 1));
        tbl.push_back(v(M1,T2,0,0,0,0,1,8'hFF, 1, 1,1,1,1, 8'hFF, 1));
        tbl.push_back(v(M1,T3,0,0,0,0,1,8'hFF, 1, 1,1,0,1, 8'hFF, 1));
        // E: T1 reload takes priority over a running countdown
        tbl.push_back(v(M2,T1,1,0,0,0,1,8'h5A, 1, 0,1,0,1, 8'hFF, 1));
        tbl.push_back(v(M2,T2,1,0,0,0,1,8'h5A, 0, 0,1,0,1, 8'hFF, 1));
        tbl.push_back(v(M2,T1,1,0,0,0,1,8'h5A, 0, 0,1,0,1, 8'hFF, 1));
        tbl.push_back(v(M2,T2,1,0,0,0,1,8'h5A, 0, 0,1,0,1, 8'hFF, 1));
        tbl.push_back(v(M2,T2,1,0,0,0,1,8'h5A, 0, 0,1,0,1, 8'hFF, 1));
        tbl.push_back(v(M2,T2,1,0,0,0,1,8'h5A, 1, 1,1,1,1, 8'h5A, 1));
        // F: I/O read
        tbl.push_back(v(M3,T1,1,0,0,1,1,8'h81, 1, 0,1,1,0, 8'h5A, 1));
        tbl.push_back(v(M3,T2,1,0,0,1,1,8'h81, 0, 0,1,1,0, 8'h5A, 1));
        tbl.push_back(v(M3,T2,1,0,0,1,1,8'h81, 1, 1,1,1,1, 8'h81, 1));
        // G: no_read cycle, countdown continues outside T2
        tbl.push_back(v(M2,T1,1,1,0,0,1,8'h81, 1, 1,1,1,1, 8'h81, 1));
        tbl.push_back(v(M2,TN,1,1,0,0,1,8'h81, 0, 1,1,1,1, 8'h81, 1));
        tbl.push_back(v(M2,TN,1,1,0,0,1,8'h81, 0, 1,1,1,1, 8'h81, 1));
        tbl.push_back(v(M2,TN,1,1,0,0,1,8'h81, 1, 1,1,1,1, 8'h81, 1));

        // Reset state
        #12;
        chk("reset rd_n", rd_d, 1); chk("reset wr_n", wr_d, 1);
        chk("reset mreq_n", mreq_d, 1); chk("reset iorq_n", iorq_d, 1);
        chk("reset di_reg", dreg_d, 8'h00); chk("reset bus_err", err_d, 0);
        chk("reset core_wait_n", cwn_d, 1);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].mc, tbl[i].ts, tbl[i].intc_n, tbl[i].no_rd,
                  tbl[i].wr, tbl[i].io, tbl[i].wait_n, tbl[i].di);
            #2;
            chk($sformatf("row%0d core_wait_n", i), cwn_d, tbl[i].cwn);
            @(posedge clk); #1;
            chk($sformatf("row%0d rd_n", i), rd_d, tbl[i].rd_n);
            chk($sformatf("row%0d wr_n", i), wr_d, tbl[i].wr_n);
            chk($sformatf("row%0d mreq_n", i), mreq_d, tbl[i].mreq_n);
            chk($sformatf("row%0d iorq_n", i), iorq_d, tbl[i].iorq_n);
            chk($sformatf("row%0d di_reg", i), dreg_d, tbl[i].di_reg);
            chk($sformatf("row%0d wr_n t2write", i), wr_w, tbl[i].wr_n_w);
        end

        // Asynchronous reset mid-T2 while dut_w holds cnt=3
        drive(M2, T1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hC3);
        @(posedge clk); #1;
        drive(M2, T2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hC3);
        #1;
        chk("pre-reset cnt3 core_wait_n", cwn_w, 0);
        chk("pre-reset rd_n", rd_w, 0);
        reset_n = 1'b0;
        #1;
        chk("async reset rd_n", rd_w, 1); chk("async reset mreq_n", mreq_w, 1);
        chk("async reset rd_n d", rd_d, 1); chk("async reset mreq_n d", mreq_d, 1);
        chk("async reset di_reg", dreg_d, 8'h00); chk("async reset di_reg w", dreg_w, 8'h00);
        chk("async reset cnt cleared", cwn_w, 1);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("post-reset T2 rd_n", rd_w, 1);
        chk("post-reset T2 mreq_n", mreq_d, 1);

        // External wait held low for a long T2
        drive(M2, T1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        @(posedge clk); #1;
        first_d = 0; first_w = 0; pulses_d = 0; pulses_w = 0; hi_d = 0;
        drive(M2, T2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk); #1;
            if (err_d) begin pulses_d++; if (first_d == 0) first_d = k; end
            if (err_w) begin pulses_w++; if (first_w == 0) first_w = k; end
            if (cwn_d) hi_d++;
        end
`ifdef TV80_WAIT_TIMEOUT_EN
        chk("timeout edge", first_d, 257);
        chk("timeout edge w", first_w, 258);
        chk("timeout pulses", pulses_d, 1);
        chk("timeout pulses w", pulses_w, 1);
        chk("timeout core_wait_n released", cwn_d, 1);
        chk("timeout high cycles", hi_d, 44);
        drive(M2, T3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        @(posedge clk); #1;
        drive(M2, T2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        #1;
        chk("timeout release clears", cwn_d, 0);
`else
        chk("no timeout edge", first_d, 0);
        chk("no timeout pulses", pulses_d, 0);
        chk("no timeout pulses w", pulses_w, 0);
        chk("no timeout high cycles", hi_d, 0);
        chk("no timeout core_wait_n", cwn_d, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/tv80_bus_ctl.md
TV80_BUS_CTL -- requirements
Module: tv80_bus_ctl

Interface
REQ-001 SHALL have parameter T2WRITE, default 0: 0 asserts wr_n from T3; nonzero asserts it from T2.
REQ-002 SHALL have parameter MEM_WAIT, default 0: inserted wait states for non-M1 memory cycles (range 0..7).
REQ-003 SHALL have parameter IO_WAIT, default 1: inserted wait states for I/O and interrupt-acknowledge cycles (range 0..7).
REQ-004 SHALL have parameter M1_WAIT, default 0: inserted wait states for opcode-fetch (M1) cycles (range 0..7).
REQ-005 SHALL have ports as follows; one clock; reset is asynchronous and active-low:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- mc  in  7  one-hot machine cycle from the core; bit0 = M1.
- ts  in  7  one-hot T-state from the core; bit1 = T1, bit2 = T2, bit3 = T3.
- intcycle_n  in  1  low during an interrupt-acknowledge M1.
- no_read  in  1  current cycle performs no read.
- write  in  1  current cycle is a write.
- iorq  in  1  current cycle is I/O.
- wait_n  in  1  external wait request, active low.
- di  in  8  external data bus.
- core_wait_n  out  1  merged wait to the core.
- rd_n, wr_n, mreq_n, iorq_n  out  1 each  registered bus strobes, active low.
- di_reg  out  8  latched read data to the core.
- bus_err  out  1  one-cycle pulse on wait timeout.

Function
REQ-006 SHALL load wait counter cnt on the clock edge at which ts[1] is high, as follows:
- M1 with intcycle_n=1: M1_WAIT.
- M1 with intcycle_n=0: IO_WAIT.
- iorq=1: IO_WAIT.
- Otherwise: MEM_WAIT.
REQ-007 SHALL decrement cnt by one on each edge where cnt is nonzero and ts[1] is low; cnt saturates at 0.
REQ-008 SHALL drive core_wait_n = wait_n AND (cnt==0) combinationally, except when overridden by REQ-015.
REQ-009 SHALL, in an M1 cycle, drive the following on the next edge when ts[1], or ts[2] with core_wait_n=0:
- rd_n = ~intcycle_n.
- mreq_n = ~intcycle_n.
- iorq_n = intcycle_n.
REQ-010 SHALL, in an M1 cycle, drive mreq_n low on the next edge while ts[3] (refresh strobe).
REQ-011 SHALL, in a non-M1 read cycle (no_read=0, write=0), drive the following on the next edge when ts[1], or ts[2] with core_wait_n=0:
- rd_n = 0.
- iorq_n = ~iorq.
- mreq_n = iorq.
REQ-012 SHALL drive a write cycle as follows, with iorq_n/mreq_n driven as in REQ-011:
- T2WRITE=0: wr_n low on the next edge when ts[2].
- T2WRITE nonzero: wr_n low on the next edge when ts[1], or ts[2] with core_wait_n=0.
REQ-013 SHALL default every strobe to 1 on any edge where no rule above applies.
REQ-014 SHALL capture di into di_reg on an edge where ts[2] and core_wait_n=1; di_reg SHALL hold otherwise.
REQ-015 SHALL time out external waits, as follows:
- tcnt (8-bit) counts consecutive edges with ts[2]=1, cnt==0 and wait_n=0.
- On reaching 255: bus_err pulses high for exactly one cycle, and core_wait_n is forced to 1 until ts[2] falls.
- tcnt clears whenever ts[2]=0 or wait_n=1.
REQ-016 SHALL let ts[1] reload cnt even if cnt is nonzero, with the reload taking priority over the decrement.

Reset
REQ-017 SHALL, while reset_n=0, immediately set:
- rd_n, wr_n, mreq_n, iorq_n to 1.
- di_reg to 8'h00.
- cnt and tcnt to 0.
- bus_err to 0.
REQ-018 SHALL abort any in-progress cycle or wait countdown on reset assertion; the first strobe after release requires a fresh ts[1].

Configuration
REQ-019 SHALL implement the REQ-015 timeout only when macro TV80_WAIT_TIMEOUT_EN is defined; when undefined, tcnt is absent, bus_err is tied 0 and core_wait_n = wait_n AND (cnt==0).

Structure
REQ-020 SHALL take the following from shared package tv80_pkg:
- ts/mc bit-index constants (T1, T2, T3, M1).
- Wait-counter width (3).
- Timeout limit (255).
REQ-021 SHALL place cnt/tcnt logic in sub-module tv80_wait_gen; strobe and data-latch logic stays in tv80_bus_ctl.

Verification
REQ-022 SHALL cover: memory read with MEM_WAIT=2, wait_n=1 -> T2 held 2 extra cycles; rd_n/mreq_n low from T1 edge through T2 end; di=8'hA5 latched into di_reg at the final T2 edge.
REQ-023 SHALL cover: I/O write with IO_WAIT=1, T2WRITE=0 -> wr_n and iorq_n low from the T2 edge; mreq_n stays 1; T2 lasts 2 cycles.
REQ-024 SHALL cover: M1 fetch with M1_WAIT=0 and external wait_n low for 3 cycles -> T2 extended 3 cycles; mreq_n low in T3 (refresh).
REQ-025 SHALL cover: interrupt ack (intcycle_n=0) -> iorq_n low, rd_n and mreq_n high, IO_WAIT waits inserted.
REQ-026 SHALL cover: with TV80_WAIT_TIMEOUT_EN and wait_n held 0 -> bus_err pulses once after 255 T2 edges and core_wait_n rises; without the macro, core_wait_n stays 0 indefinitely.
REQ-027 SHALL cover: reset_n pulsed low mid-T2 with cnt=3 -> all strobes 1, di_reg 8'h00, cnt 0, asynchronously.
